// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates the ALU result path and the memory-load path onto the single
//   write port of the 32x32 register file. Each source uses a valid/ready
//   handshake. The winning request is registered and appears one cycle later
//   as wb_en/wb_addr/wb_data/wb_src. Memory loads win by default.
//
//   Optional feature macro: STARVE_GUARD_EN
//     defined   - a 4-bit starvation counter and a NORMAL/FORCE_ALU FSM force
//                 an ALU grant after STARVE_LIMIT consecutive lost arbitrations
//     undefined - strict MEM priority, no counter or FSM
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   wb_stall   in   register file cannot accept a write; no grants this cycle
//   alu_valid  in   ALU writeback request
//   alu_addr   in   ALU destination register
//   alu_data   in   ALU result
//   alu_ready  out  ALU request accepted this cycle (combinational)
//   mem_valid  in   load writeback request
//   mem_addr   in   load destination register
//   mem_data   in   load data
//   mem_ready  out  load request accepted this cycle (combinational)
//   wb_en      out  register-file write enable (registered, one cycle per grant)
//   wb_addr    out  register-file write address (registered, holds when idle)
//   wb_data    out  register-file write data (registered, holds when idle)
//   wb_src     out  source of the write: 0 = ALU, 1 = MEM (registered)
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_src
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("wb_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic grant_alu;
  logic grant_mem;
  logic force_alu;

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef STARVE_GUARD_EN
  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_ALU = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign force_alu = (state_q == FORCE_ALU);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;

    // Count only arbitrations the ALU actually lost to MEM; stalls hold.
    if (!alu_valid || grant_alu) begin
      cnt_d = '0;
    end else if (mem_valid && grant_mem && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 4'd1;
    end

    // Entering FORCE_ALU on the next-count value makes the forced grant land
    // on the cycle right after the STARVE_LIMIT-th loss.
    unique case (state_q)
      NORMAL: begin
        if (cnt_d == LIMIT) state_d = FORCE_ALU;
      end
      FORCE_ALU: begin
        if (grant_alu || !alu_valid) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end
`else
  assign force_alu = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst && !wb_stall) begin
      if (alu_valid && mem_valid) begin
        if (force_alu) grant_alu = 1'b1;
        else           grant_mem = 1'b1;
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_src  <= 1'b0;
    end else begin
      wb_en <= grant_alu | grant_mem;
      if (grant_alu) begin
        wb_addr <= alu_addr;
        wb_data <= alu_data;
        wb_src  <= 1'b0;
      end else if (grant_mem) begin
        wb_addr <= mem_addr;
        wb_data <= mem_data;
        wb_src  <= 1'b1;
      end
    end
  end

endmodule
